// File: rtl/usb_tx_pkt_fifo.sv
// Packet-aware USB IN transmit FIFO: committed bytes become readable, storage is freed on ACK, rewound on retry.
// Optional build macro USB_TXFIFO_ABORT_EN adds the wabort input to discard uncommitted bytes.
module usb_tx_pkt_fifo #(
   parameter int DSIZE = 8,
   parameter int ASIZE = 9
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic             write,
   input  logic [DSIZE-1:0] iData,
   input  logic             commit,
   input  logic             read,
   output logic [DSIZE-1:0] oData,
   input  logic             txact,
   input  logic             txack,
   input  logic             txretry,
`ifdef USB_TXFIFO_ABORT_EN
   input  logic             wabort,
`endif
   output logic             full,
   output logic             empty,
   output logic [ASIZE:0]   rdnum,
   output logic [ASIZE:0]   freenum,
   output logic [ASIZE:0]   txlen
);

   localparam logic [ASIZE:0] DEPTH = {1'b1, {ASIZE{1'b0}}};
   localparam logic [ASIZE:0] ONE   = {{ASIZE{1'b0}}, 1'b1};

   typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT} state_t;

   state_t           state_q, state_d;
   logic [ASIZE:0]   wp_q, wp_d;
   logic [ASIZE:0]   cwp_q, cwp_d;
   logic [ASIZE:0]   rp_q, rp_d;
   logic [ASIZE:0]   sp_q, sp_d;
   logic [ASIZE:0]   rdnum_q, freenum_q;
   logic [ASIZE:0]   used;
   logic [DSIZE-1:0] oData_q;
   logic [DSIZE-1:0] mem [2**ASIZE];
   logic             wr_en, rd_en, abort;

`ifdef USB_TXFIFO_ABORT_EN
   assign abort = wabort;
`else
   assign abort = 1'b0;
`endif

   assign used  = wp_q - sp_q;
   assign full  = (used == DEPTH);
   assign empty = (rp_q == cwp_q);
   assign txlen = rp_q - sp_q;
   assign wr_en = write & ~full & ~abort;
   assign rd_en = read & txact & ~empty & (state_q != ST_WAIT);

   assign oData   = oData_q;
   assign rdnum   = rdnum_q;
   assign freenum = freenum_q;

   always_ff @(posedge CLK) begin
      if (wr_en) mem[wp_q[ASIZE-1:0]] <= iData;
   end

   // Commit captures the post-increment write pointer so a same-cycle byte is published.
   always_comb begin
      wp_d  = wp_q;
      cwp_d = cwp_q;
      if (abort) begin
         wp_d = cwp_q;
      end else begin
         if (wr_en)  wp_d  = wp_q + ONE;
         if (commit) cwp_d = wp_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rp_d    = rp_q;
      sp_d    = sp_q;
      if (rd_en) rp_d = rp_q + ONE;
      case (state_q)
         ST_IDLE: if (txact) state_d = ST_SEND;
         ST_SEND: if (!txact) state_d = ST_WAIT;
         ST_WAIT: begin
            if (txack) begin
               sp_d    = rp_q;
               state_d = ST_IDLE;
            end else if (txretry || txact) begin
               rp_d    = sp_q;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q   <= ST_IDLE;
         wp_q      <= '0;
         cwp_q     <= '0;
         rp_q      <= '0;
         sp_q      <= '0;
         oData_q   <= '0;
         rdnum_q   <= '0;
         freenum_q <= DEPTH;
      end else begin
         state_q   <= state_d;
         wp_q      <= wp_d;
         cwp_q     <= cwp_d;
         rp_q      <= rp_d;
         sp_q      <= sp_d;
         rdnum_q   <= cwp_q - rp_q;
         freenum_q <= DEPTH - used;
         if (rd_en) oData_q <= mem[rp_q[ASIZE-1:0]];
      end
   end

endmodule

// File: tb/tb_usb_tx_pkt_fifo.sv
// Directed self-checking bench for usb_tx_pkt_fifo; covers abort behaviour when USB_TXFIFO_ABORT_EN is defined.
module tb_usb_tx_pkt_fifo;

   logic       CLK = 1'b0;
   logic       RSTn = 1'b0;
   logic       write = 1'b0, commit = 1'b0, read = 1'b0;
   logic       txact = 1'b0, txack = 1'b0, txretry = 1'b0;
   logic [7:0] iData = '0;
   logic [7:0] oData;
   logic       full, empty;
   logic [9:0] rdnum, freenum, txlen;
`ifdef USB_TXFIFO_ABORT_EN
   logic       wabort = 1'b0;
`endif

   int total = 0;
   int bad   = 0;

   usb_tx_pkt_fifo #(.DSIZE(8), .ASIZE(9)) dut (
      .CLK(CLK), .RSTn(RSTn), .write(write), .iData(iData), .commit(commit),
      .read(read), .oData(oData), .txact(txact), .txack(txack), .txretry(txretry),
`ifdef USB_TXFIFO_ABORT_EN
      .wabort(wabort),
`endif
      .full(full), .empty(empty), .rdnum(rdnum), .freenum(freenum), .txlen(txlen)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic put(input logic [7:0] d, input logic c);
      write = 1'b1; iData = d; commit = c;
      tick();
      write = 1'b0; commit = 1'b0;
   endtask

   task automatic pull(input string tag, input int exp);
      read = 1'b1;
      tick();
      read = 1'b0;
      check(tag, oData, exp);
   endtask

   task automatic finish_pkt(input logic ack, input logic retry);
      txact = 1'b0;
      tick();
      txack = ack; txretry = retry;
      tick();
      txack = 1'b0; txretry = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge CLK);
      #1;
      check("rst_empty_hold", empty, 1);
      RSTn = 1'b1;
      tick();
      check("rst_oData", oData, 0);
      check("rst_full", full, 0);
      check("rst_empty", empty, 1);
      check("rst_rdnum", rdnum, 0);
      check("rst_freenum", freenum, 512);
      check("rst_txlen", txlen, 0);

      // uncommitted bytes are invisible
      put(8'h11, 0); put(8'h12, 0); put(8'h13, 0); put(8'h14, 0);
      txact = 1'b1; read = 1'b1;
      tick();
      read = 1'b0;
      check("nocommit_empty", empty, 1);
      check("nocommit_oData", oData, 0);
      check("nocommit_freenum", freenum, 508);
      finish_pkt(0, 1);
      commit = 1'b1;
      tick();
      commit = 1'b0;
      check("commit_empty", empty, 0);
      check("commit_rdnum_lag", rdnum, 0);
      tick();
      check("commit_rdnum", rdnum, 4);
      txact = 1'b1;
      pull("p1_d0", 8'h11); pull("p1_d1", 8'h12); pull("p1_d2", 8'h13); pull("p1_d3", 8'h14);
      finish_pkt(1, 0);
      tick();
      check("p1_freenum", freenum, 512);

      // 3-byte packet, commit together with last write, ACK
      put(8'h21, 0); put(8'h22, 0); put(8'h23, 1);
      check("p2_empty", empty, 0);
      tick();
      check("p2_rdnum", rdnum, 3);
      check("p2_freenum", freenum, 509);
      txact = 1'b1;
      pull("p2_d0", 8'h21); pull("p2_d1", 8'h22); pull("p2_d2", 8'h23);
      check("p2_txlen", txlen, 3);
      finish_pkt(1, 0);
      check("p2_txlen_ack", txlen, 0);
      check("p2_freenum_lag", freenum, 509);
      tick();
      check("p2_freenum_ack", freenum, 512);
      check("p2_empty_ack", empty, 1);

      // retry, implicit retry, then ACK winning over retry
      put(8'hA0, 0); put(8'hA1, 1);
      txact = 1'b1;
      pull("p3_d0", 8'hA0); pull("p3_d1", 8'hA1);
      finish_pkt(0, 1);
      tick();
      check("p3_rdnum_retry", rdnum, 2);
      check("p3_empty_retry", empty, 0);
      check("p3_txlen_retry", txlen, 0);
      txact = 1'b1;
      pull("p3_r1_d0", 8'hA0); pull("p3_r1_d1", 8'hA1);
      check("p3_txlen", txlen, 2);
      txact = 1'b0;
      tick();
      txact = 1'b1;
      tick();
      check("p3_implicit_txlen", txlen, 0);
      pull("p3_r2_d0", 8'hA0); pull("p3_r2_d1", 8'hA1);
      finish_pkt(1, 1);
      check("p3_ackwins_empty", empty, 1);
      tick();
      check("p3_ackwins_rdnum", rdnum, 0);

      // fill the whole RAM, reject writes while full
      for (int i = 0; i < 512; i++) put(8'(i) ^ 8'h5A, (i == 511) ? 1'b1 : 1'b0);
      check("full_set", full, 1);
      put(8'hEE, 1);
      check("full_hold", full, 1);
      tick();
      check("full_freenum", freenum, 0);
      check("full_rdnum", rdnum, 512);
      txact = 1'b1;
      for (int i = 0; i < 512; i++) begin
         read = 1'b1;
         tick();
         read = 1'b0;
         check("full_data", oData, 8'(i) ^ 8'h5A);
      end
      check("drained_full", full, 1);
      check("drained_empty", empty, 1);
      check("drained_txlen", txlen, 512);
      finish_pkt(1, 0);
      check("ack_full", full, 0);
      put(8'h77, 1);
      check("after_full_empty", empty, 0);
      tick();
      check("after_full_freenum", freenum, 511);
      txact = 1'b1;
      pull("after_full_d", 8'h77);
      finish_pkt(1, 0);

      // advance pointers to 1022, then run a packet across the RAM boundary
      for (int i = 0; i < 500; i++) put(8'(i), (i == 499) ? 1'b1 : 1'b0);
      txact = 1'b1; read = 1'b1;
      repeat (500) tick();
      read = 1'b0;
      check("adv_last", oData, 8'hF3);
      finish_pkt(1, 0);
      check("adv_rp_bit9", dut.rp_q[9], 1);
      put(8'hB0, 0); put(8'hB1, 0); put(8'hB2, 0); put(8'hB3, 1);
      tick();
      check("wrap_rdnum", rdnum, 4);
      check("wrap_freenum", freenum, 508);
      txact = 1'b1;
      pull("wrap_d0", 8'hB0); pull("wrap_d1", 8'hB1); pull("wrap_d2", 8'hB2); pull("wrap_d3", 8'hB3);
      check("wrap_txlen", txlen, 4);
      check("wrap_rp_bit9", dut.rp_q[9], 0);
      finish_pkt(1, 0);
      tick();
      check("wrap_freenum_ack", freenum, 512);

`ifdef USB_TXFIFO_ABORT_EN
      put(8'hC0, 0); put(8'hC1, 1);
      put(8'hC2, 0); put(8'hC3, 0); put(8'hC4, 0);
      wabort = 1'b1; write = 1'b1; iData = 8'hDD;
      tick();
      wabort = 1'b0; write = 1'b0;
      tick();
      check("abort_freenum", freenum, 510);
      check("abort_rdnum", rdnum, 2);
      txact = 1'b1;
      pull("abort_d0", 8'hC0); pull("abort_d1", 8'hC1);
      check("abort_empty", empty, 1);
      finish_pkt(1, 0);
      put(8'hC9, 1);
      txact = 1'b1;
      pull("abort_next", 8'hC9);
      finish_pkt(1, 0);
`endif

      // asynchronous reset mid-packet
      put(8'h55, 1); put(8'h56, 0);
      txact = 1'b1;
      pull("mid_d0", 8'h55);
      RSTn = 1'b0;
      #1;
      check("mid_rst_oData", oData, 0);
      check("mid_rst_empty", empty, 1);
      check("mid_rst_rdnum", rdnum, 0);
      check("mid_rst_freenum", freenum, 512);
      check("mid_rst_txlen", txlen, 0);
      check("mid_rst_full", full, 0);
      txact = 1'b0;
      tick();
      RSTn = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/usb_tx_pkt_fifo.md
# usb_tx_pkt_fifo

Packet-aware transmit FIFO for the USB IN direction, between the application write port and the SIE/UTMI transmit path. Bytes become visible to the transmitter only after the writer commits the packet. The transmitter drains bytes while `txact` is high. The packet's storage is released on host ACK, or rewound for retransmission on retry/timeout, so the same bytes are resent.

## Interface
- `DSIZE`, 8, data width in bits
- `ASIZE`, 9, address width; depth is 2^ASIZE bytes
- `CLK`  in  1  clock, all logic on rising edge
- `RSTn`  in  1  reset, asynchronous, active-low
- `write`  in  1  write strobe; `iData` is stored when `write & ~full`
- `iData`  in  DSIZE  write data
- `commit`  in  1  end of packet on the write side; publishes all written bytes to the reader
- `read`  in  1  read strobe from the transmitter
- `oData`  out  DSIZE  registered read data
- `txact`  in  1  transmit active, level; high for the duration of one packet send
- `txack`  in  1  one-cycle pulse: host ACKed the last sent packet
- `txretry`  in  1  one-cycle pulse: no ACK or timeout; resend the packet
- `full`  out  1  no free space; space is counted against the unacknowledged start pointer
- `empty`  out  1  no committed, unread bytes
- `rdnum`  out  ASIZE+1  registered count of committed, unread bytes
- `freenum`  out  ASIZE+1  registered count of free bytes
- `txlen`  out  ASIZE+1  bytes read since the last ACK or rewind

## Operation
- Pointers are ASIZE+1 bits: `wp` (write), `cwp` (committed write), `rp` (read) and `sp` (start of the unacknowledged packet).
  - The RAM is addressed with the low ASIZE bits.
  - All differences are modulo 2^(ASIZE+1).
- Write side:
  - `write & ~full` stores `iData` at `wp` and increments `wp`.
  - `commit` sets `cwp` to `wp`. If an accepted write occurs in the same cycle, `cwp` becomes `wp+1`, so the byte is included.
  - `commit` with no new bytes has no effect.
- `full` = (`wp - sp`) == 2^ASIZE. `empty` = (`rp == cwp`).
  - Both are combinational from the pointers.
- Read FSM states: IDLE, SEND and WAIT.
  - IDLE: if `txact` → SEND.
  - SEND: if `~txact` → WAIT.
  - WAIT with `txack`: `sp <= rp` (frees the storage) → IDLE.
  - WAIT with `txretry`: `rp <= sp` → IDLE.
  - WAIT with `txack` and `txretry` together: `txack` wins.
  - WAIT with `txact` high and no ack or retry: implicit retry (`rp <= sp`) → IDLE.
  - `txack` and `txretry` are ignored outside WAIT.
- A read is honoured when `read & txact & ~empty` and the state is not WAIT.
  - An honoured read loads `oData` from RAM[`rp`] and increments `rp`.
  - A read when empty is ignored, and `oData` holds its value.
- `txlen` = `rp - sp`, combinational.
- `rdnum` = `cwp - rp` and `freenum` = 2^ASIZE - (`wp - sp`), both registered one cycle after any pointer change.
- Reset values: `oData` 0, `full` 0, `empty` 1, `rdnum` 0, `freenum` 2^ASIZE, `txlen` 0. All pointers 0, state IDLE.
- Asserting reset mid-packet discards all contents immediately.

## Timing
- Read latency is 1 cycle: `oData` is valid on the edge after the accepted `read`.
- A committed byte is readable in the cycle after the `commit` edge, i.e. `empty` falls one cycle after `commit`.
- `full` deasserts in the cycle after the `txack` edge.
- A write and a read in the same cycle are both honoured, provided the write is not full and the read is not empty.
- `rdnum` and `freenum` lag the pointers by 1 cycle.
- Wrap-around: pointer bit ASIZE toggles at each wrap, so full and empty are distinguished across the RAM boundary.

## Configuration
- `USB_TXFIFO_ABORT_EN` defined: the block adds input port `wabort` (1 bit).
  - `wabort` sets `wp <= cwp`, discarding uncommitted bytes.
  - `wabort` has priority over `write` and `commit` in the same cycle.
- Macro undefined: there is no `wabort` port. Uncommitted bytes persist until committed.

## Test plan
- Write 4 bytes 0x11..0x14 without commit and pulse `read` with `txact`=1 → `empty` stays 1 and `oData` stays 0. Then `commit` → `empty`=0 next cycle and `rdnum`=4 one cycle later.
- Commit 3 bytes, send them, drop `txact`, pulse `txack` → `txlen`=3, then `sp`=`rp`, `freenum`=509 → 512 after ack, state IDLE.
- Commit 0xA0,0xA1; send both; `txretry` → `rp` rewinds, `rdnum`=2. Resend → `oData` sequence 0xA0,0xA1 again.
- Fill 512 bytes and commit; read all 512 without ack → `full` stays 1 and `empty`=1. `txack` → `full`=0 next cycle and the write succeeds.
- Run a packet that crosses the 511→0 boundary (start at 510, length 4) → bytes are read in order, and pointer bit 9 toggles.
- With `USB_TXFIFO_ABORT_EN`: commit 2 bytes, write 3, assert `wabort` → `wp`=`cwp`, `freenum` reflects 2 used, and only 2 bytes are readable.
